pll_loop_ctrl: RTL and testbench
================================

# pll_loop_ctrl

Digital PLL loop controller that consumes the phase/frequency detector outputs (`up`, `down`, `ref_clk_is_faster`, `ref_clk_is_slower`, `freq_check_done`, `calibration_done`) and drives the DCO control words. A coarse-band search FSM steps `coarse_code` on each frequency-check result. A fine proportional-integral loop filter then converts up/down phase error into `fine_code`. A lock detector reports steady state and falls back to coarse search when the detector flags a frequency error again.

## Interface
- `COARSE_W`, 6: coarse band code width.
- `FINE_W`, 8: fine code width; `FINE_MID` = 2^(FINE_W-1).
- `COARSE_INIT`, 32: coarse code after reset.
- `INT_W`, 12: signed integrator width.
- `KP`, 4: proportional gain (unsigned integer).
- `KI_SHIFT`, 2: integrator arithmetic right shift.
- `LOCK_CYCLES`, 64: quiet cycles in FINE before lock.
- `ref_clk` in 1: sole clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `up` in 1: detector up pulse; asynchronous to `ref_clk`.
- `down` in 1: detector down pulse; asynchronous to `ref_clk`.
- `ref_clk_is_faster` in 1: frequency result, `ref_clk` domain.
- `ref_clk_is_slower` in 1: frequency result, `ref_clk` domain.
- `freq_check_done` in 1: frequency result valid, `ref_clk` domain, level.
- `calibration_done` in 1: no frequency error for the stable window, `ref_clk` domain.
- `coarse_code` out COARSE_W: DCO band select.
- `fine_code` out FINE_W: DCO fine tune, registered.
- `locked` out 1: lock indicator, registered.
- `state` out 2: FSM state; IDLE=0, COARSE=1, FINE=2, LOCKED=3.

## Operation
- **Synchronizers:** `up` and `down` each pass through a 2-flop synchronizer, giving `up_s` and `down_s`.
- **Phase error:** `err` = +1 if `up_s & ~down_s`; −1 if `down_s & ~up_s`; otherwise 0.
- **Frequency-check edge:** `freq_check_done` is registered into `fcd_q`. `fcd_edge` = `freq_check_done & ~fcd_q`.
- **Step direction on `fcd_edge`:** +1 if faster only; −1 if slower only; none if both or neither (illegal, ignored).
- **IDLE:** held for one cycle after reset release, then moves to COARSE.
- **COARSE, on `fcd_edge` with a valid direction:**
  - `coarse_code` += direction, saturating at 0 and 2^COARSE_W−1.
  - `last_dir` is stored.
  - Moves to FINE if the direction is opposite to a non-zero `last_dir`.
  - Moves to FINE if the step was blocked by saturation (code unchanged).
- **COARSE, on `calibration_done` without `fcd_edge`:** moves to FINE.
- **COARSE, simultaneous `fcd_edge` and `calibration_done`:** the step is applied and the `fcd_edge` rules decide the transition; `calibration_done` is ignored that cycle.
- **COARSE hold:** integrator held at 0; `fine_code` = `FINE_MID`.
- **FINE / LOCKED, integrator:** `integ` += `err` each cycle, saturating at ±(2^(INT_W−1)−1).
- **FINE / LOCKED, fine code:** `fine_code` = sat(`FINE_MID` + (`integ_next` >>> KI_SHIFT) + KP·`err`) into [0, 2^FINE_W−1]. The sum is computed signed, with width ≥ INT_W+2.
- **Quiet counter:** `quiet_cnt` increments each FINE cycle without `fcd_edge`.
  - At `LOCKED_CYCLES`−1 the state moves to LOCKED and `locked` rises.
  - The counter saturates and clears on leaving FINE/LOCKED.
- **Loss of lock:** `fcd_edge` in FINE or LOCKED causes:
  - `locked` falls.
  - `integ` clears to 0 and `last_dir` clears to 0.
  - State returns to COARSE.
  - The coarse step for that same edge is applied that cycle.

## Timing
- **Reset values (asynchronous):**
  - `coarse_code` = `COARSE_INIT`, `fine_code` = `FINE_MID`, `locked` = 0, `state` = IDLE.
  - `integ`, `last_dir`, `quiet_cnt`, `fcd_q` and synchronizer flops = 0.
- **Reset mid-operation:** all outputs take their reset values immediately, regardless of clock.
- **Phase-error latency:** `up`/`down` sampled at edge n gives `err` at n+2, and `fine_code` is visible after edge n+3.
- **`fcd_edge` response:** `coarse_code`, `state` and `locked` change on the edge at which `fcd_edge` is evaluated, so they are visible one cycle after `freq_check_done` rises.
- **Level input:** `freq_check_done` held high for multiple cycles produces one step only.
- **Re-arming:** a new step requires `freq_check_done` to drop for at least one cycle.
- **Lock timing:** LOCKED is entered exactly `LOCK_CYCLES` cycles after entering FINE with no `fcd_edge`.
- **State changes:** occur only on the rules above. LOCKED and FINE share the same loop-filter datapath.

## Test plan
- **Reset:** assert `rst_n` low, then release → `coarse_code`=32, `fine_code`=128, `locked`=0, `state`=0; one cycle later `state`=1.
- **Coarse search to reversal:** three `freq_check_done` pulses (1 cycle high, 5 low) with faster=1 → `coarse_code` 33, 34, 35. Then a slower pulse → 34 and `state`=2.
- **Saturation:** `COARSE_INIT`=63 with a faster pulse → `coarse_code` stays 63 and `state`=2.
- **Fine filter:** in FINE, `up`=1, `down`=0 for 10 cycles → `fine_code` settles at 128+(10>>>2)+4=134. Then `up`=`down`=0 → 130. Holding `up` 2100 cycles → integrator saturates at 2047 and `fine_code` clips to 255.
- **Lock and loss of lock:** 64 quiet FINE cycles → `locked`=1, `state`=3. Then a slower pulse → next cycle `locked`=0, `state`=1, `fine_code`=128, `coarse_code` −1.
- **Corner cases:** faster and slower both high at an edge → no change. `freq_check_done` held high for 20 cycles → one step. `rst_n` low in LOCKED → outputs reset asynchronously.

Source files
------------

// File: rtl/pll_loop_ctrl_if.sv
// pll_loop_ctrl_if: the detector-facing and DCO-facing signals of the PLL loop
// controller, bundled so the controller and its environment connect through
// one port.
//
//   Detector -> controller : up, down, ref_clk_is_faster, ref_clk_is_slower,
//                            freq_check_done, calibration_done
//   Controller -> DCO      : coarse_code[COARSE_W], fine_code[FINE_W],
//                            locked, state[2]
//
// Modports:
//   master - the detector/DCO side; drives the detector results and observes
//            the control words.
//   slave  - the loop controller itself.
interface pll_loop_ctrl_if #(
  parameter int COARSE_W = 6,
  parameter int FINE_W   = 8
) ();

  logic                up;
  logic                down;
  logic                ref_clk_is_faster;
  logic                ref_clk_is_slower;
  logic                freq_check_done;
  logic                calibration_done;
  logic [COARSE_W-1:0] coarse_code;
  logic [FINE_W-1:0]   fine_code;
  logic                locked;
  logic [1:0]          state;

  modport master (
    output up, down, ref_clk_is_faster, ref_clk_is_slower,
           freq_check_done, calibration_done,
    input  coarse_code, fine_code, locked, state
  );

  modport slave (
    input  up, down, ref_clk_is_faster, ref_clk_is_slower,
           freq_check_done, calibration_done,
    output coarse_code, fine_code, locked, state
  );

endinterface

// File: rtl/pll_loop_ctrl.sv
// pll_loop_ctrl: digital PLL loop controller.
//
// A coarse-band search steps coarse_code on each frequency-check result until
// the direction reverses, the band saturates or calibration reports no
// frequency error. A proportional-integral filter then turns the
// (synchronized) up/down phase error into fine_code. After LOCK_CYCLES quiet
// cycles the loop reports lock; a new frequency-check result at any time in
// FINE/LOCKED drops lock and resumes the coarse search.
//
// Ports:
//   ref_clk - sole clock, all state on the rising edge
//   rst_n   - asynchronous active-low reset
//   bus     - pll_loop_ctrl_if.slave: detector inputs (up/down are
//             asynchronous to ref_clk, the rest are ref_clk-domain) and the
//             coarse_code / fine_code / locked / state outputs
module pll_loop_ctrl #(
  parameter int COARSE_W    = 6,
  parameter int FINE_W      = 8,
  parameter int COARSE_INIT = 32,
  parameter int INT_W       = 12,
  parameter int KP          = 4,
  parameter int KI_SHIFT    = 2,
  parameter int LOCK_CYCLES = 64
) (
  input  logic           ref_clk,
  input  logic           rst_n,
  pll_loop_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int FINE_MID = 2 ** (FINE_W - 1);
  localparam int IW1      = INT_W + 1;
  localparam int SW       = INT_W + FINE_W + 2;
  localparam int QW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [COARSE_W-1:0]    COARSE_MAX = '1;
  localparam logic signed [IW1-1:0]  INT_LIM    = IW1'(2 ** (INT_W - 1) - 1);
  localparam logic signed [IW1-1:0]  INT_NLIM   = -INT_LIM;
  localparam logic signed [SW-1:0]   FINE_MAX_S = SW'(2 ** FINE_W - 1);
  localparam logic [QW-1:0]          QUIET_TOP  = QW'(LOCK_CYCLES - 1);
  localparam logic signed [1:0]      DIR_POS    = 2'sb01;
  localparam logic signed [1:0]      DIR_NEG    = 2'sb11;
  localparam logic signed [1:0]      DIR_NONE   = 2'sb00;

  // Synchronizers and phase-error register
  logic up_meta, up_s, down_meta, down_s;
  logic signed [1:0] err_q, err_d;

  // Frequency-check edge detect
  logic fcd_q, fcd_edge;

  // Loop state
  state_t                   state_q, state_d;
  logic [COARSE_W-1:0]      coarse_q, coarse_d;
  logic [FINE_W-1:0]        fine_q, fine_d;
  logic signed [INT_W-1:0]  integ_q, integ_d;
  logic signed [1:0]        last_dir_q, last_dir_d;
  logic [QW-1:0]            quiet_q, quiet_d;
  logic                     locked_q, locked_d;

  // Datapath intermediates
  logic signed [1:0]        step_dir;
  logic                     step_valid, step_blocked, reversal;
  logic [COARSE_W-1:0]      coarse_stepped;
  logic signed [IW1-1:0]    integ_sum;
  logic signed [INT_W-1:0]  integ_sat, integ_shr;
  logic signed [SW-1:0]     fine_sum;
  logic [FINE_W-1:0]        fine_sat;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  // up/down arrive asynchronously: two flops each before any logic sees them.
  // The phase error is registered once more, so an up/down sample taken at
  // edge n reaches err_q at n+2 and fine_code at n+3.
  // NOTE: clocked state is written with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      up_meta   <= 1'b0;
      up_s      <= 1'b0;
      down_meta <= 1'b0;
      down_s    <= 1'b0;
      err_q     <= DIR_NONE;
      fcd_q     <= 1'b0;
    end else begin
      up_meta   <= bus.up;
      up_s      <= up_meta;
      down_meta <= bus.down;
      down_s    <= down_meta;
      err_q     <= err_d;
      fcd_q     <= bus.freq_check_done;
    end
  end

  always_comb begin
    if (up_s && !down_s)      err_d = DIR_POS;
    else if (down_s && !up_s) err_d = DIR_NEG;
    else                      err_d = DIR_NONE;
  end

  // freq_check_done is a level; only its rising edge requests a step.
  assign fcd_edge = bus.freq_check_done & ~fcd_q;

  // ---------------------------------------------------------------------------
  // Coarse step: direction, saturation and reversal detection
  // ---------------------------------------------------------------------------
  always_comb begin
    step_dir = DIR_NONE;
    if (bus.ref_clk_is_faster && !bus.ref_clk_is_slower)      step_dir = DIR_POS;
    else if (bus.ref_clk_is_slower && !bus.ref_clk_is_faster) step_dir = DIR_NEG;
  end

  assign step_valid   = (step_dir != DIR_NONE);
  assign step_blocked = ((step_dir == DIR_POS) && (coarse_q == COARSE_MAX)) ||
                        ((step_dir == DIR_NEG) && (coarse_q == '0));
  assign reversal     = ((step_dir == DIR_POS) && (last_dir_q == DIR_NEG)) ||
                        ((step_dir == DIR_NEG) && (last_dir_q == DIR_POS));

  always_comb begin
    coarse_stepped = coarse_q;
    if (!step_blocked) begin
      if (step_dir == DIR_POS)      coarse_stepped = coarse_q + COARSE_W'(1);
      else if (step_dir == DIR_NEG) coarse_stepped = coarse_q - COARSE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // PI loop filter: saturating integrator, then signed sum clipped to the
  // fine-code range. The sum is wide enough that it can never wrap before
  // the clip.
  // ---------------------------------------------------------------------------
  always_comb begin
    integ_sum = IW1'(integ_q) + IW1'(err_q);
    if (integ_sum > INT_LIM)       integ_sat = INT_W'(INT_LIM);
    else if (integ_sum < INT_NLIM) integ_sat = INT_W'(INT_NLIM);
    else                           integ_sat = INT_W'(integ_sum);

    integ_shr = integ_sat >>> KI_SHIFT;
    fine_sum  = SW'(FINE_MID) + SW'(integ_shr) + SW'(KP) * SW'(err_q);

    if (fine_sum[SW-1])             fine_sat = '0;
    else if (fine_sum > FINE_MAX_S) fine_sat = '1;
    else                            fine_sat = FINE_W'(fine_sum);
  end

  // ---------------------------------------------------------------------------
  // Loop FSM: next state and all next-register values
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    coarse_d   = coarse_q;
    fine_d     = fine_q;
    integ_d    = integ_q;
    last_dir_d = last_dir_q;
    quiet_d    = quiet_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_COARSE;
      end

      ST_COARSE: begin
        integ_d = '0;
        fine_d  = FINE_W'(FINE_MID);
        quiet_d = '0;
        // A frequency result outranks calibration_done in the same cycle;
        // an illegal (both/neither) result is dropped but still consumes it.
        if (fcd_edge) begin
          if (step_valid) begin
            coarse_d   = coarse_stepped;
            last_dir_d = step_dir;
            if (reversal || step_blocked) state_d = ST_FINE;
          end
        end else if (bus.calibration_done) begin
          state_d = ST_FINE;
        end
      end

      ST_FINE, ST_LOCKED: begin
        if (fcd_edge) begin
          // Frequency error reported again: restart the search from the
          // current band, applying this edge's step immediately.
          state_d    = ST_COARSE;
          integ_d    = '0;
          last_dir_d = DIR_NONE;
          fine_d     = FINE_W'(FINE_MID);
          quiet_d    = '0;
          if (step_valid) coarse_d = coarse_stepped;
        end else begin
          integ_d = integ_sat;
          fine_d  = fine_sat;
          if (quiet_q != QUIET_TOP) quiet_d = quiet_q + QW'(1);
          if ((state_q == ST_FINE) && (quiet_q == QUIET_TOP)) state_d = ST_LOCKED;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      coarse_q   <= COARSE_W'(COARSE_INIT);
      fine_q     <= FINE_W'(FINE_MID);
      integ_q    <= '0;
      last_dir_q <= DIR_NONE;
      quiet_q    <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      coarse_q   <= coarse_d;
      fine_q     <= fine_d;
      integ_q    <= integ_d;
      last_dir_q <= last_dir_d;
      quiet_q    <= quiet_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.coarse_code = coarse_q;
  assign bus.fine_code   = fine_q;
  assign bus.locked      = locked_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// tb_pll_loop_ctrl: self-checking bench for pll_loop_ctrl.
// A behavioural loop model (plain integers, a phase-error delay queue) runs
// beside the DUT and is compared on every falling edge; directed sequences
// pin the model with hand-computed values; a random phase exercises the
// filter, search and lock/unlock paths together.
module tb_pll_loop_ctrl;

  localparam int COARSE_W    = 6;
  localparam int FINE_W      = 8;
  localparam int COARSE_INIT = 32;
  localparam int INT_W       = 12;
  localparam int KP          = 4;
  localparam int KI_SHIFT    = 2;
  localparam int LOCK_CYCLES = 64;
  localparam int FINE_MID    = 2 ** (FINE_W - 1);
  localparam int FINE_MAX    = 2 ** FINE_W - 1;
  localparam int COARSE_MAX  = 2 ** COARSE_W - 1;
  localparam int INT_LIM     = 2 ** (INT_W - 1) - 1;

  logic ref_clk = 1'b0;
  logic rst_n   = 1'b1;

  int checks = 0;
  int errors = 0;

  pll_loop_ctrl_if #(.COARSE_W(COARSE_W), .FINE_W(FINE_W)) bus ();
  pll_loop_ctrl_if #(.COARSE_W(COARSE_W), .FINE_W(FINE_W)) bus2 ();

  pll_loop_ctrl #(
    .COARSE_W(COARSE_W), .FINE_W(FINE_W), .COARSE_INIT(COARSE_INIT),
    .INT_W(INT_W), .KP(KP), .KI_SHIFT(KI_SHIFT), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Second instance starting at the top band, for the saturation case.
  pll_loop_ctrl #(
    .COARSE_W(COARSE_W), .FINE_W(FINE_W), .COARSE_INIT(63),
    .INT_W(INT_W), .KP(KP), .KI_SHIFT(KI_SHIFT), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut2 (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .bus     (bus2)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model. Mode: 0 idle, 1 coarse search, 2 fine, 3 locked.
  // ph holds phase errors still in flight: an up/down sample taken at an edge
  // drives the filter three edges later.
  // ---------------------------------------------------------------------------
  int m_state, m_coarse, m_fine, m_integ, m_last_dir, m_quiet;
  int m_fcd_prev;
  int ph[$];

  always @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state    = 0;
      m_coarse   = COARSE_INIT;
      m_fine     = FINE_MID;
      m_integ    = 0;
      m_last_dir = 0;
      m_quiet    = 0;
      m_fcd_prev = 0;
      ph         = '{0, 0, 0};
    end else begin
      int raw, e, dir, newc;
      bit edge_seen;
      raw = (bus.up && !bus.down) ? 1 : ((bus.down && !bus.up) ? -1 : 0);
      e   = ph.pop_front();
      ph.push_back(raw);
      edge_seen  = bus.freq_check_done && (m_fcd_prev == 0);
      m_fcd_prev = int'(bus.freq_check_done);
      dir = (bus.ref_clk_is_faster && !bus.ref_clk_is_slower) ? 1 :
            ((bus.ref_clk_is_slower && !bus.ref_clk_is_faster) ? -1 : 0);
      newc = clamp(m_coarse + dir, 0, COARSE_MAX);

      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        m_integ = 0;
        m_fine  = FINE_MID;
        m_quiet = 0;
        if (edge_seen) begin
          if (dir != 0) begin
            if ((m_last_dir != 0 && dir == -m_last_dir) || newc == m_coarse) m_state = 2;
            m_coarse   = newc;
            m_last_dir = dir;
          end
        end else if (bus.calibration_done) begin
          m_state = 2;
        end
      end else begin
        if (edge_seen) begin
          m_state    = 1;
          m_integ    = 0;
          m_last_dir = 0;
          m_fine     = FINE_MID;
          m_quiet    = 0;
          m_coarse   = newc;
        end else begin
          m_integ = clamp(m_integ + e, -INT_LIM, INT_LIM);
          m_fine  = clamp(FINE_MID + (m_integ >>> KI_SHIFT) + KP * e, 0, FINE_MAX);
          m_quiet++;
          if (m_state == 2 && m_quiet == LOCK_CYCLES) m_state = 3;
        end
      end
    end
  end

  // Compare process: every falling edge out of reset.
  bit cmp_en = 1'b0;
  always @(negedge ref_clk) begin
    if (cmp_en && rst_n) begin
      check("coarse_code", int'(bus.coarse_code), m_coarse);
      check("fine_code",   int'(bus.fine_code),   m_fine);
      check("locked",      int'(bus.locked),      (m_state == 3) ? 1 : 0);
      check("state",       int'(bus.state),       m_state);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change only on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge ref_clk);
    @(negedge ref_clk);
  endtask

  task automatic fcd_pulse(input bit faster, input bit slower, input int high, input int low);
    bus.ref_clk_is_faster = faster;
    bus.ref_clk_is_slower = slower;
    bus.freq_check_done   = 1'b1;
    repeat (high) tick();
    bus.freq_check_done   = 1'b0;
    bus.ref_clk_is_faster = 1'b0;
    bus.ref_clk_is_slower = 1'b0;
    repeat (low) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_coarse"}, int'(bus.coarse_code), COARSE_INIT);
    check({tag, "_fine"},   int'(bus.fine_code),   FINE_MID);
    check({tag, "_locked"}, int'(bus.locked),      0);
    check({tag, "_state"},  int'(bus.state),       0);
  endtask

  task automatic random_phase(input int cycles, input int fcd_odds);
    int fcd_left = 0;
    int gap = 1;
    for (int i = 0; i < cycles; i++) begin
      bus.up   = 1'($urandom_range(0, 1));
      bus.down = 1'($urandom_range(0, 1));
      bus.calibration_done = ($urandom_range(0, 31) == 0);
      if (fcd_left > 0) begin
        fcd_left--;
        if (fcd_left == 0) begin
          bus.freq_check_done   = 1'b0;
          bus.ref_clk_is_faster = 1'b0;
          bus.ref_clk_is_slower = 1'b0;
          gap = 0;
        end
      end else if (gap > 0 && $urandom_range(0, fcd_odds - 1) == 0) begin
        bit f;
        f = 1'($urandom_range(0, 1));
        bus.ref_clk_is_faster = f;
        bus.ref_clk_is_slower = ~f;
        bus.freq_check_done   = 1'b1;
        fcd_left = $urandom_range(1, 3);
      end else begin
        gap++;
      end
      tick();
    end
    bus.freq_check_done   = 1'b0;
    bus.ref_clk_is_faster = 1'b0;
    bus.ref_clk_is_slower = 1'b0;
    bus.calibration_done  = 1'b0;
    bus.up   = 1'b0;
    bus.down = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.up = 1'b0; bus.down = 1'b0;
    bus.ref_clk_is_faster = 1'b0; bus.ref_clk_is_slower = 1'b0;
    bus.freq_check_done = 1'b0; bus.calibration_done = 1'b0;
    bus2.up = 1'b0; bus2.down = 1'b0;
    bus2.ref_clk_is_faster = 1'b0; bus2.ref_clk_is_slower = 1'b0;
    bus2.freq_check_done = 1'b0; bus2.calibration_done = 1'b0;

    // Reset and IDLE -> COARSE
    #2 rst_n = 1'b0;
    repeat (3) @(negedge ref_clk);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1 check_reset_values("released");
    @(negedge ref_clk);
    check("idle_exit_state", int'(bus.state), 1);

    // Saturation at the top band (second instance)
    bus2.ref_clk_is_faster = 1'b1;
    bus2.freq_check_done   = 1'b1;
    tick();
    check("sat_coarse", int'(bus2.coarse_code), 63);
    check("sat_state",  int'(bus2.state),       2);
    bus2.ref_clk_is_faster = 1'b0;
    bus2.freq_check_done   = 1'b0;

    // Coarse search: three faster steps
    fcd_pulse(1'b1, 1'b0, 1, 5);
    check("coarse_step1", int'(bus.coarse_code), 33);
    fcd_pulse(1'b1, 1'b0, 1, 5);
    check("coarse_step2", int'(bus.coarse_code), 34);
    fcd_pulse(1'b1, 1'b0, 1, 5);
    check("coarse_step3", int'(bus.coarse_code), 35);
    check("coarse_still", int'(bus.state),       1);

    // Illegal direction ignored; a held level gives one step only
    fcd_pulse(1'b1, 1'b1, 1, 5);
    check("illegal_coarse", int'(bus.coarse_code), 35);
    check("illegal_state",  int'(bus.state),       1);
    fcd_pulse(1'b1, 1'b0, 20, 3);
    check("level_coarse", int'(bus.coarse_code), 36);

    // Reversal -> FINE
    fcd_pulse(1'b0, 1'b1, 1, 5);
    check("reverse_coarse", int'(bus.coarse_code), 35);
    check("reverse_state",  int'(bus.state),       2);

    // Fine filter
    bus.up = 1'b1;
    repeat (10) tick();
    bus.up = 1'b0;
    repeat (3) tick();
    check("fine_up10", int'(bus.fine_code), 134);
    tick();
    check("fine_quiet", int'(bus.fine_code), 130);
    bus.up = 1'b1;
    repeat (2100) tick();
    check("fine_clip",   int'(bus.fine_code), 255);
    check("long_state",  int'(bus.state),     3);
    check("long_locked", int'(bus.locked),    1);
    bus.up = 1'b0;
    repeat (5) tick();

    // Loss of lock
    bus.ref_clk_is_slower = 1'b1;
    bus.freq_check_done   = 1'b1;
    tick();
    check("lol_locked", int'(bus.locked),      0);
    check("lol_state",  int'(bus.state),       1);
    check("lol_fine",   int'(bus.fine_code),   128);
    check("lol_coarse", int'(bus.coarse_code), 34);
    bus.ref_clk_is_slower = 1'b0;
    bus.freq_check_done   = 1'b0;
    repeat (5) tick();

    // calibration_done -> FINE, then exact lock timing
    bus.calibration_done = 1'b1;
    tick();
    bus.calibration_done = 1'b0;
    check("cal_state", int'(bus.state), 2);
    bus.up = 1'b1;
    repeat (20) tick();
    bus.up = 1'b0;
    repeat (43) tick();
    check("prelock_state",  int'(bus.state),  2);
    check("prelock_locked", int'(bus.locked), 0);
    tick();
    check("lock_state",  int'(bus.state),  3);
    check("lock_locked", int'(bus.locked), 1);

    // Asynchronous reset while locked, away from any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge ref_clk);
    rst_n = 1'b1;

    // Randomized operation against the model
    random_phase(300, 8);
    random_phase(600, 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
